neural_layer_engine: RTL and testbench
======================================

Name: neural_layer_engine

Overview:
- Parametrised successor to the single fixed-output accelerator: one fully-connected neural layer, N_IN signed inputs to N_OUT neurons.
- Weights and biases are loaded through a write port. Inputs are streamed in over a valid/ready handshake.
- Each neuron is computed by a single time-shared MAC, then scaled, saturated and optionally rectified.
- Results are streamed out over a valid/ready handshake. The block sits between the input feature buffer and the next layer or the top-level output register.

Parameters:
- DATA_W, 8, width of signed inputs, weights, biases and outputs (two's complement).
- N_IN, 4, inputs per neuron (>=1).
- N_OUT, 4, neurons in the layer (>=1).
- ACC_W, 20, signed accumulator width; must be >= 2*DATA_W + clog2(N_IN+1).
- FRAC_W, 4, fractional bits of weights; result is arithmetically shifted right by FRAC_W.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- w_we  in  1  weight/bias write strobe.
- w_addr  in  clog2(N_OUT*(N_IN+1))  address; j*(N_IN+1)+i = weight i of neuron j; i=N_IN = bias of neuron j.
- w_data  in  DATA_W  signed weight/bias value.
- in_valid  in  1  input element valid.
- in_ready  out  1  engine accepts input element.
- in_data  in  DATA_W  signed input element, delivered in order x[0]..x[N_IN-1].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  DATA_W  signed neuron result.
- out_idx  out  clog2(N_OUT) (min 1)  neuron index of out_data.
- busy  out  1  high in any state other than IDLE/LOAD with zero elements collected.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, out_idx=0, busy=0; FSM=IDLE; counters and accumulator cleared.
- Weight memory is not cleared by reset; contents are retained across reset.
- States: IDLE, LOAD, COMPUTE, EMIT.
- IDLE:
  - in_ready=1.
  - Writes with w_we=1 are accepted only in IDLE (memory[w_addr]<=w_data at the edge).
  - Addresses >= N_OUT*(N_IN+1) are ignored.
  - An input handshake (in_valid&in_ready) stores x[0] and moves to LOAD (or directly to COMPUTE when N_IN=1).
- LOAD:
  - in_ready=1; busy=1; each handshake stores the next element.
  - On the handshake of x[N_IN-1]: neuron j=0, acc<=0, go to COMPUTE.
  - w_we is ignored.
- COMPUTE:
  - in_ready=0; one MAC per cycle: acc <= acc + x[i]*w[j][i], i=0..N_IN-1; product is full 2*DATA_W signed, sign-extended to ACC_W.
  - After the N_IN-th MAC edge, the next edge computes the result and enters EMIT with out_valid=1.
  - Result computation: s = acc + (bias_j <<< FRAC_W); r = s >>> FRAC_W (arithmetic); saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Latency: out_valid rises N_IN+1 edges after the edge that accepted x[N_IN-1] (or that completed the previous output handshake).
- EMIT:
  - out_data/out_idx are held stable while out_valid=1 and out_ready=0.
  - On the handshake (out_valid&out_ready): if j<N_OUT-1, then j<=j+1, acc<=0, back to COMPUTE, out_valid<=0.
  - If j=N_OUT-1, go to IDLE with out_valid<=0 and the input buffer invalidated.
- Throughput: one result per N_IN+2 cycles with out_ready tied high.
- Simultaneous w_we and input handshake in IDLE: both take effect; the write uses the pre-computation memory snapshot for that address only if written before COMPUTE reads it (it always is, since the write occurs in IDLE).
- Reset mid-operation: the FSM returns to IDLE immediately; a partial input vector and the accumulator are discarded; out_valid drops asynchronously.
- Accumulator never wraps given the ACC_W constraint. No rounding; the shift truncates toward -inf.

Optional Feature:
- Macro NLE_RELU_EN.
- Defined: after saturation, negative results are replaced by 0 (ReLU); out_data range is [0, 2^(DATA_W-1)-1].
- Undefined: linear activation; signed saturated result is passed unchanged.

Test Plan:
- Defaults; all weights 16 (1.0), biases 0; inputs 1,2,3,4 -> out_idx 0..3 each out_data=10, first out_valid 5 cycles after the last input accept.
- Neuron 2 bias=5, others as above -> out_idx 2 gives 15, others 10.
- Weights 127, inputs 127 (acc 64516) -> out_data=127 all neurons. Weights -128, inputs 127 -> -128 without NLE_RELU_EN, 0 with it.
- Weights -16, inputs 1,2,3,4 -> out_data=-10 (0xF6) without NLE_RELU_EN, 0 with it.
- Hold out_ready=0 for 5 cycles at neuron 1 -> out_valid and out_data stay constant; no extra outputs; after release, neurons 1..3 follow in order.
- Assert reset (0) during COMPUTE of neuron 2, then release -> out_valid=0, state IDLE, no further outputs; resend the same inputs -> identical results (weights retained).
- w_we during LOAD/COMPUTE with new value 0 -> ignored; results unchanged.

Source files
------------

// File: rtl/neural_layer_engine.sv
// Fully-connected layer: N_IN signed inputs to N_OUT neurons through one time-shared MAC,
// then scale, saturate and (with NLE_RELU_EN defined) rectify. Default build is linear.
module neural_layer_engine #(
   parameter int DATA_W = 8,
   parameter int N_IN   = 4,
   parameter int N_OUT  = 4,
   parameter int ACC_W  = 20,
   parameter int FRAC_W = 4,
   localparam int DEPTH = N_OUT * (N_IN + 1),
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int OW    = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     w_we,
   input  logic [AW-1:0]            w_addr,
   input  logic signed [DATA_W-1:0] w_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_data,
   output logic [OW-1:0]            out_idx,
   output logic                     busy
);

   localparam int CW = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int IW = $clog2(N_IN + 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_LOAD    = 2'd1;
   localparam logic [1:0] S_COMPUTE = 2'd2;
   localparam logic [1:0] S_EMIT    = 2'd3;

   localparam logic [AW:0]    DEPTH_L = (AW + 1)'(DEPTH);
   localparam logic [CW-1:0]  X_LAST  = CW'(N_IN - 1);
   localparam logic [IW-1:0]  I_LAST  = IW'(N_IN);
   localparam logic [OW-1:0]  J_LAST  = OW'(N_OUT - 1);

   localparam logic signed [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic signed [ACC_W-1:0]  SAT_MAX = ACC_W'(OUT_MAX);
   localparam logic signed [ACC_W-1:0]  SAT_MIN = ACC_W'(OUT_MIN);

   logic [1:0]               state_q, state_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [IW-1:0]            i_q, i_d;
   logic [OW-1:0]            j_q, j_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic                     in_ready_q, in_ready_d;
   logic                     out_valid_q, out_valid_d;
   logic signed [DATA_W-1:0] out_data_q, out_data_d;
   logic [OW-1:0]            out_idx_q, out_idx_d;

   logic signed [DATA_W-1:0] mem_q  [DEPTH];
   logic signed [DATA_W-1:0] xbuf_q [N_IN];

   logic                       in_hs;
   logic [AW-1:0]              rd_addr;
   logic signed [DATA_W-1:0]   w_cur;
   logic signed [DATA_W-1:0]   x_cur;
   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    acc_mac;
   logic signed [ACC_W-1:0]    bias_sh;
   logic signed [ACC_W-1:0]    sum_s;
   logic signed [ACC_W-1:0]    r_s;
   logic signed [DATA_W-1:0]   sat_res;
   logic signed [DATA_W-1:0]   act_res;

   assign in_hs     = in_valid & in_ready_q;
   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;
   assign busy      = (state_q != S_IDLE);

   // Weight/bias memory and input buffer carry no reset: contents survive a reset pulse.
   always_ff @(posedge clk) begin
      if (w_we && (state_q == S_IDLE) && ({1'b0, w_addr} < DEPTH_L)) begin
         mem_q[w_addr] <= w_data;
      end
   end

   always_ff @(posedge clk) begin
      if (in_hs) begin
         xbuf_q[cnt_q] <= in_data;
      end
   end

   // With i_q == N_IN the same address arithmetic lands on the neuron's bias word.
   always_comb begin
      rd_addr = AW'(int'(j_q) * (N_IN + 1) + int'(i_q));
      w_cur   = mem_q[rd_addr];
      x_cur   = '0;
      for (int unsigned k = 0; k < N_IN; k++) begin
         if (32'(i_q) == k) begin
            x_cur = xbuf_q[k];
         end
      end
      prod    = (2*DATA_W)'(x_cur) * (2*DATA_W)'(w_cur);
      acc_mac = acc_q + ACC_W'(prod);
      bias_sh = ACC_W'(w_cur) <<< FRAC_W;
      sum_s   = acc_q + bias_sh;
      r_s     = sum_s >>> FRAC_W;
      if (r_s > SAT_MAX) begin
         sat_res = OUT_MAX;
      end else if (r_s < SAT_MIN) begin
         sat_res = OUT_MIN;
      end else begin
         sat_res = r_s[DATA_W-1:0];
      end
`ifdef NLE_RELU_EN
      act_res = sat_res[DATA_W-1] ? '0 : sat_res;
`else
      act_res = sat_res;
`endif
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      i_d         = i_q;
      j_d         = j_q;
      acc_d       = acc_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      case (state_q)
         S_IDLE: begin
            if (in_hs) begin
               if (N_IN == 1) begin
                  state_d = S_COMPUTE;
                  j_d     = '0;
                  i_d     = '0;
                  acc_d   = '0;
               end else begin
                  state_d = S_LOAD;
                  cnt_d   = CW'(1);
               end
            end
         end
         S_LOAD: begin
            if (in_hs) begin
               if (cnt_q == X_LAST) begin
                  state_d = S_COMPUTE;
                  cnt_d   = '0;
                  j_d     = '0;
                  i_d     = '0;
                  acc_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         S_COMPUTE: begin
            if (i_q != I_LAST) begin
               acc_d = acc_mac;
               i_d   = i_q + IW'(1);
            end else begin
               out_data_d  = act_res;
               out_idx_d   = j_q;
               out_valid_d = 1'b1;
               state_d     = S_EMIT;
            end
         end
         default: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               if (j_q == J_LAST) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end else begin
                  state_d = S_COMPUTE;
                  j_d     = j_q + OW'(1);
                  i_d     = '0;
                  acc_d   = '0;
               end
            end
         end
      endcase
      in_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         i_q         <= '0;
         j_q         <= '0;
         acc_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         i_q         <= i_d;
         j_q         <= j_d;
         acc_q       <= acc_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
      end
   end

endmodule

// File: tb/tb_neural_layer_engine.sv
// Bench for neural_layer_engine: scoreboard fed by a floor-division layer model, directed
// cases from the plan, then randomized weights/inputs/backpressure. Honours NLE_RELU_EN.
module tb_neural_layer_engine;

   localparam int DATA_W = 8;
   localparam int N_IN   = 4;
   localparam int N_OUT  = 4;
   localparam int ACC_W  = 20;
   localparam int FRAC_W = 4;
   localparam int DEPTH  = N_OUT * (N_IN + 1);
   localparam int AW     = 5;
   localparam int OW     = 2;
   localparam int MAXV   = (1 << (DATA_W - 1)) - 1;
   localparam int MINV   = -(1 << (DATA_W - 1));
`ifdef NLE_RELU_EN
   localparam int EXP_NEG10  = 0;
   localparam int EXP_NEG128 = 0;
`else
   localparam int EXP_NEG10  = -10;
   localparam int EXP_NEG128 = -128;
`endif

   typedef int vec_t [N_IN];
   typedef struct { int idx; int data; } exp_t;

   logic                     clk = 1'b0;
   logic                     reset = 1'b0;
   logic                     w_we = 1'b0;
   logic [AW-1:0]            w_addr = '0;
   logic signed [DATA_W-1:0] w_data = '0;
   logic                     in_valid = 1'b0;
   logic                     in_ready;
   logic signed [DATA_W-1:0] in_data = '0;
   logic                     out_valid;
   logic                     out_ready = 1'b1;
   logic signed [DATA_W-1:0] out_data;
   logic [OW-1:0]            out_idx;
   logic                     busy;

   neural_layer_engine #(
      .DATA_W(DATA_W), .N_IN(N_IN), .N_OUT(N_OUT), .ACC_W(ACC_W), .FRAC_W(FRAC_W)
   ) dut (
      .clk(clk), .reset(reset), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_idx(out_idx), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   w_sh [N_OUT][N_IN+1];
   exp_t q [$];
   int   got [N_OUT];
   int   lat_ref = -1;
   int   rdy_mode = 1;   // 0 manual, 1 always ready, 2 random

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timed out, required event never seen (t=%0t)", name, $time);
   endtask

   // Floor-division reference for one neuron.
   function automatic int model(input int j, input vec_t xv);
      int s, r, d;
      d = 1 << FRAC_W;
      s = w_sh[j][N_IN] * d;
      for (int i = 0; i < N_IN; i++) s += xv[i] * w_sh[j][i];
      r = (s >= 0) ? (s / d) : -((-s + d - 1) / d);
      if (r > MAXV) r = MAXV;
      if (r < MINV) r = MINV;
`ifdef NLE_RELU_EN
      if (r < 0) r = 0;
`endif
      return r;
   endfunction

   always @(posedge clk) begin
      #1;
      if (rdy_mode == 1) out_ready = 1'b1;
      else if (rdy_mode == 2) out_ready = ($urandom_range(0, 3) != 0);
   end

   logic               pv = 1'b0, pr = 1'b0;
   logic signed [7:0]  pd = '0;
   logic [OW-1:0]      pi = '0;
   always @(negedge clk) begin
      if (!reset) begin
         pv = 1'b0;
      end else begin
         if (pv && !pr) begin
            check("hold_valid", int'(out_valid), 1);
            check("hold_data", int'(out_data), int'(pd));
            check("hold_idx", int'(out_idx), int'(pi));
         end
         if (out_valid && !pv && lat_ref >= 0) begin
            check("latency", cyc - lat_ref, N_IN + 1);
            lat_ref = -1;
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_output: got idx %0d data %0d, required none", out_idx, out_data);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("out_idx", int'(out_idx), e.idx);
               check("out_data", int'(out_data), e.data);
               got[e.idx] = int'(out_data);
               if (e.idx != N_OUT - 1) lat_ref = cyc + 1;
            end
         end
         pv = out_valid; pr = out_ready; pd = out_data; pi = out_idx;
      end
   end

   task automatic write_w(input int addr, input int val);
      w_we = 1'b1;
      w_addr = AW'(addr);
      w_data = DATA_W'(val);
      @(posedge clk); #1;
      w_we = 1'b0;
      if (addr < DEPTH) w_sh[addr / (N_IN + 1)][addr % (N_IN + 1)] = val;
   endtask

   task automatic load_all(input int wv, input int bv);
      for (int j = 0; j < N_OUT; j++)
         for (int i = 0; i <= N_IN; i++)
            write_w(j * (N_IN + 1) + i, (i == N_IN) ? bv : wv);
   endtask

   task automatic send_vector(input vec_t xv, input bit gaps);
      for (int e = 0; e < N_IN; e++) begin
         int t = 0;
         bit acc;
         if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         end
         in_valid = 1'b1;
         in_data = DATA_W'(xv[e]);
         forever begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1;
            if (acc) break;
            if (++t > 200) begin timeout("input_accept"); in_valid = 1'b0; return; end
         end
      end
      in_valid = 1'b0;
      lat_ref = cyc;
      for (int j = 0; j < N_OUT; j++) begin
         exp_t e;
         e.idx = j;
         e.data = model(j, xv);
         q.push_back(e);
      end
   endtask

   task automatic wait_idle();
      int t = 0;
      @(negedge clk);
      while (busy) begin
         @(negedge clk);
         if (++t > 1000) begin timeout("wait_idle"); break; end
      end
      @(posedge clk); #1;
   endtask

   task automatic wait_out(input int idx);
      int t = 0;
      forever begin
         @(negedge clk);
         if (out_valid && int'(out_idx) == idx) return;
         if (++t > 300) begin timeout("wait_out"); return; end
      end
   endtask

   vec_t x1234;
   vec_t xmax;
   vec_t xr;

   initial begin
      x1234 = '{1, 2, 3, 4};
      xmax  = '{127, 127, 127, 127};

      #23;
      check("rst_in_ready", int'(in_ready), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_data", int'(out_data), 0);
      check("rst_out_idx", int'(out_idx), 0);
      check("rst_busy", int'(busy), 0);
      #4 reset = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("idle_in_ready", int'(in_ready), 1);
      @(posedge clk); #1;

      load_all(16, 0);
      send_vector(x1234, 1'b0);
      wait_idle();
      for (int j = 0; j < N_OUT; j++) check("unit_w", got[j], 10);

      write_w(2 * (N_IN + 1) + N_IN, 5);
      send_vector(x1234, 1'b0);
      wait_idle();
      check("bias_n2", got[2], 15);
      check("bias_n0", got[0], 10);

      load_all(127, 0);
      send_vector(xmax, 1'b0);
      wait_idle();
      check("sat_pos", got[3], 127);

      load_all(-128, 0);
      send_vector(xmax, 1'b0);
      wait_idle();
      check("sat_neg", got[1], EXP_NEG128);

      load_all(-16, 0);
      send_vector(x1234, 1'b0);
      wait_idle();
      check("neg_w", got[0], EXP_NEG10);

      // backpressure on neuron 1
      load_all(16, 0);
      write_w(2 * (N_IN + 1) + N_IN, 5);
      send_vector(x1234, 1'b0);
      wait_out(0);
      rdy_mode = 0;
      @(posedge clk); #1;
      out_ready = 1'b0;
      wait_out(1);
      repeat (5) @(negedge clk);
      check("stall_valid", int'(out_valid), 1);
      check("stall_idx", int'(out_idx), 1);
      check("stall_data", int'(out_data), 10);
      @(posedge clk); #1;
      out_ready = 1'b1;
      rdy_mode = 1;
      wait_idle();
      check("after_stall_n3", got[3], 10);

      // reset while neuron 2 computes
      send_vector(x1234, 1'b0);
      wait_out(1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      #2 reset = 1'b0;
      q.delete();
      lat_ref = -1;
      #1;
      check("midrst_out_valid", int'(out_valid), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_out_data", int'(out_data), 0);
      @(posedge clk); #3 reset = 1'b1;
      begin
         int seen = 0;
         repeat (12) begin @(negedge clk); if (out_valid) seen++; end
         check("no_out_after_rst", seen, 0);
      end
      @(posedge clk); #1;
      send_vector(x1234, 1'b0);
      wait_idle();
      check("resend_n2", got[2], 15);

      // writes while not idle must be ignored
      fork
         send_vector(x1234, 1'b0);
         begin
            @(posedge clk); #1;
            w_we = 1'b1; w_addr = '0; w_data = '0;
            repeat (10) begin @(posedge clk); #1; end
            w_we = 1'b0;
         end
      join
      wait_idle();
      check("busy_write_n0", got[0], 10);

      // randomized phase
      rdy_mode = 2;
      for (int v = 0; v < 30; v++) begin
         wait_idle();
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 8)) begin
               int a;
               a = (($urandom_range(0, 9) == 0) ? $urandom_range(DEPTH, 31) : $urandom_range(0, DEPTH - 1));
               write_w(a, int'($urandom_range(0, 255)) - 128);
            end
         end
         for (int i = 0; i < N_IN; i++) xr[i] = int'($urandom_range(0, 255)) - 128;
         send_vector(xr, 1'b1);
      end
      wait_idle();
      check("drained", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
